// File: rtl/timestamp_fifo_arbiter_pkg.sv
// Shared types, widths and the cyclic-priority pick used by the timestamp FIFO arbiters.
package timestamp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MAX_SRC    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // One-hot grant of the first set bit of req at or after ptr, wrapping at n (n <= MAX_SRC).
  function automatic logic [MAX_SRC-1:0] rr_pick(
    input logic [MAX_SRC-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_SRC-1:0] gnt;
    logic [3:0]         idx;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_SRC; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(n)) begin
        idx = idx - 4'(n);
      end
      if ((k < n) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/timestamp_fifo_arbiter_rr_priority_sel.sv
// Combinational cyclic-priority one-hot selector over N requesters.
module rr_priority_sel
  import timestamp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt
);

  logic [MAX_SRC-1:0] req_ext;
  logic [MAX_SRC-1:0] gnt_ext;
  logic               unused_gnt;

  always_comb begin
    req_ext         = '0;
    req_ext[N-1:0]  = req;
    gnt_ext         = rr_pick(req_ext, ptr, N);
    gnt             = gnt_ext[N-1:0];
  end

  // Bits above N can never be granted.
  assign unused_gnt = ^gnt_ext;

endmodule

// File: rtl/timestamp_fifo_arbiter.sv
// Record-atomic round-robin merge of NUM_SRC FWFT word FIFOs into one 32-bit FWFT stream.
module timestamp_fifo_arbiter
  import timestamp_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int RECORD_WORDS = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                          BUS_CLK,
  input  logic                          BUS_RST_N,
  input  logic [NUM_SRC-1:0]            SRC_ENABLE,
  input  logic [NUM_SRC-1:0]            SRC_FIFO_EMPTY,
  input  logic [DATA_WIDTH*NUM_SRC-1:0] SRC_FIFO_DATA,
  output logic [NUM_SRC-1:0]            SRC_FIFO_READ,
  input  logic                          FIFO_READ,
  output logic                          FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0]         FIFO_DATA,
  output logic [NUM_SRC-1:0]            GRANT,
  output logic                          ERROR,
  input  logic                          ERROR_CLR
);

  arb_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [3:0]           word_cnt_q, word_cnt_d;
  logic [15:0]          stall_cnt_q, stall_cnt_d;
  logic                 error_q, error_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    pick;
  logic [DATA_WIDTH-1:0] data_masked [NUM_SRC];
  logic [DATA_WIDTH-1:0] data_mux;
  logic                  fifo_empty;
  logic                  beat;
  logic [2:0]            g_idx;
  logic [2:0]            ptr_after;
  logic                  record_last;
  logic                  stall_hit;
  logic                  set_err;

  assign req = SRC_ENABLE & ~SRC_FIFO_EMPTY;

  rr_priority_sel #(
    .N (NUM_SRC)
  ) u_rr_sel (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick)
  );

  // Grant is one-hot or zero, so an AND-OR mux suffices and yields 0 while idle.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_mux
    assign data_masked[gi] = grant_q[gi] ? SRC_FIFO_DATA[DATA_WIDTH*gi +: DATA_WIDTH] : '0;
  end

  always_comb begin
    data_mux = '0;
    g_idx    = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      data_mux = data_mux | data_masked[i];
      if (grant_q[i]) begin
        g_idx = 3'(i);
      end
    end
  end

  assign fifo_empty    = ~|(grant_q & ~SRC_FIFO_EMPTY);
  assign beat          = FIFO_READ & ~fifo_empty;
  assign SRC_FIFO_READ = grant_q & {NUM_SRC{beat}};
  assign ptr_after     = (g_idx == 3'(NUM_SRC - 1)) ? 3'd0 : g_idx + 3'd1;
  assign record_last   = (word_cnt_q == 4'(RECORD_WORDS - 1));
  assign stall_hit     = ({1'b0, stall_cnt_q} + 17'd1) >= 17'(TIMEOUT);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    set_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d     = pick;
          word_cnt_d  = 4'd0;
          stall_cnt_d = 16'd0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          stall_cnt_d = 16'd0;
          if (record_last) begin
            word_cnt_d = 4'd0;
            grant_d    = '0;
            rr_ptr_d   = ptr_after;
            state_d    = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 4'd1;
          end
        end else if (fifo_empty) begin
          // Only an empty granted source counts; a stalled reader never times out.
          if (stall_hit) begin
            set_err     = 1'b1;
            stall_cnt_d = 16'd0;
            word_cnt_d  = 4'd0;
            grant_d     = '0;
            rr_ptr_d    = ptr_after;
            state_d     = IDLE;
          end else if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    error_d = set_err | (error_q & ~ERROR_CLR);
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      word_cnt_q  <= 4'd0;
      stall_cnt_q <= 16'd0;
      error_q     <= 1'b0;
      rr_ptr_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      error_q     <= error_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign FIFO_EMPTY = fifo_empty;
  assign FIFO_DATA  = data_mux;
  assign GRANT      = grant_q;
  assign ERROR      = error_q;

endmodule

// File: tb/tb_timestamp_fifo_arbiter.sv
// Bench: source FIFOs as arrays, record-level reference model, per-cycle output comparison.
module tb_timestamp_fifo_arbiter;

  localparam int N     = 4;
  localparam int RW    = 3;
  localparam int TO    = 4;
  localparam int DEPTH = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    en;
  logic [N-1:0]    src_empty;
  logic [32*N-1:0] src_data;
  logic [N-1:0]    src_read;
  logic            rd;
  logic            fifo_empty;
  logic [31:0]     fifo_data;
  logic [N-1:0]    grant;
  logic            err;
  logic            clr;

  always #5 clk = ~clk;

  timestamp_fifo_arbiter #(
    .NUM_SRC      (N),
    .RECORD_WORDS (RW),
    .TIMEOUT      (TO)
  ) dut (
    .BUS_CLK        (clk),
    .BUS_RST_N      (rst_n),
    .SRC_ENABLE     (en),
    .SRC_FIFO_EMPTY (src_empty),
    .SRC_FIFO_DATA  (src_data),
    .SRC_FIFO_READ  (src_read),
    .FIFO_READ      (rd),
    .FIFO_EMPTY     (fifo_empty),
    .FIFO_DATA      (fifo_data),
    .GRANT          (grant),
    .ERROR          (err),
    .ERROR_CLR      (clr)
  );

  logic [31:0] mem [N][DEPTH];
  int          head [N];
  int          tail [N];
  int          rec_id = 0;

  // Reference model: current owner (-1 idle), words taken, empty-stall run, next priority, error.
  int m_owner, m_taken, m_stall, m_next;
  bit m_err;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic int cnt(input int s);
    return tail[s] - head[s];
  endfunction

  task automatic push_word(input int s, input logic [31:0] w);
    if (tail[s] < DEPTH) begin
      mem[s][tail[s]] = w;
      tail[s]++;
    end
  endtask

  task automatic push_record(input int s);
    for (int j = 0; j < RW; j++)
      push_word(s, {8'(s), 8'(rec_id), 8'(j), 8'($urandom)});
    rec_id++;
  endtask

  task automatic drive_src();
    for (int s = 0; s < N; s++) begin
      src_empty[s] = (cnt(s) == 0);
      src_data[32*s +: 32] = (cnt(s) == 0) ? 32'($urandom) : mem[s][head[s]];
    end
  endtask

  task automatic model_update();
    bit set;
    bit found;
    logic [31:0] w;
    if (!rst_n) begin
      m_owner = -1; m_taken = 0; m_stall = 0; m_next = 0; m_err = 1'b0;
    end else begin
      set = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int s;
          s = (m_next + k) % N;
          if (!found && en[s] && cnt(s) > 0) begin
            found = 1'b1; m_owner = s; m_taken = 0; m_stall = 0;
          end
        end
      end else if (cnt(m_owner) > 0 && rd) begin
        w = mem[m_owner][head[m_owner]];
        head[m_owner]++;
        $display("beat src=%0d word=%0d data=%08h t=%0t", m_owner, m_taken, w, $time);
        m_taken++;
        m_stall = 0;
        if (m_taken == RW) begin
          m_next = (m_owner + 1) % N; m_owner = -1; m_taken = 0;
        end
      end else if (cnt(m_owner) == 0) begin
        m_stall++;
        if (m_stall == TO) begin
          set = 1'b1;
          $display("timeout src=%0d t=%0t", m_owner, $time);
          m_next = (m_owner + 1) % N; m_owner = -1; m_taken = 0; m_stall = 0;
        end
      end
      m_err = set ? 1'b1 : (clr ? 1'b0 : m_err);
    end
  endtask

  // Inputs are already applied; compare away from the edge, then advance the model past the edge.
  task automatic cycle();
    logic [N-1:0] exp_read, exp_grant;
    logic         exp_empty;
    logic [31:0]  exp_data;
    drive_src();
    exp_read = '0; exp_grant = '0; exp_empty = 1'b1; exp_data = '0;
    if (m_owner >= 0) begin
      exp_grant = N'(1) << m_owner;
      exp_empty = (cnt(m_owner) == 0);
      if (!exp_empty) exp_data = mem[m_owner][head[m_owner]];
      if (rd && !exp_empty) exp_read = exp_grant;
    end
    @(negedge clk);
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("fifo_empty", 32'(fifo_empty), 32'(exp_empty));
    chk("src_read", 32'(src_read), 32'(exp_read));
    chk("error", 32'(err), 32'(m_err));
    if (m_owner < 0 || !exp_empty) chk("fifo_data", fifo_data, exp_data);
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_first_word(input int s);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      cycle();
      reached = (m_owner == s && m_taken == 1);
    end
    chk("wait_bound", 32'(reached), 32'd1);
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin head[s] = 0; tail[s] = 0; end
    rst_n = 1'b0; en = '0; rd = 1'b0; clr = 1'b0;
    drive_src();
    @(posedge clk);
    #1;
    model_update();

    // Reset held with every source loaded, then fairness over 8 records.
    for (int s = 0; s < N; s++) begin push_record(s); push_record(s); end
    en = '1; rd = 1'b1;
    run(2);
    rst_n = 1'b1;
    run(40);

    // Single source granted straight out of reset.
    rst_n = 1'b0;
    push_record(1);
    run(1);
    rst_n = 1'b1;
    run(8);

    // Reader toggling: no stall counting, no error.
    push_record(2);
    for (int i = 0; i < 10; i++) begin
      rd = (i % 2 == 0);
      cycle();
    end
    rd = 1'b1;
    run(3);

    // Source 0 supplies one word then empties; source 1 waits behind it.
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    push_word(0, 32'hA0A0_0001);
    push_record(1);
    run(14);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    run(3);

    // Enable dropped mid-record, then reset mid-record.
    push_record(3); push_record(3);
    wait_first_word(3);
    en[3] = 1'b0;
    run(6);
    push_record(1); push_record(0); push_record(2);
    wait_first_word(1);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    en = '1;
    run(30);

    // Random traffic with partial records, enables, clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      rd    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      for (int s = 0; s < N; s++) begin
        if (cnt(s) < 12 && $urandom_range(0, 7) == 0) push_record(s);
        if ($urandom_range(0, 63) == 0) push_word(s, 32'($urandom));
      end
      cycle();
    end
    rst_n = 1'b1; en = '1; rd = 1'b1; clr = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timestamp_fifo_arbiter.md
Name: timestamp_fifo_arbiter

Overview:
- Merges the word FIFOs of up to NUM_SRC timestamp cores into one 32-bit FWFT FIFO stream toward the readout/SiTCP data path.
- Round-robin arbitration at record granularity: once a source is granted, exactly RECORD_WORDS words are passed from it before any other source is served, so multi-word timestamp records are never interleaved.
- Sits in the BUS_CLK domain between the timestamp core FIFO ports and the downstream FIFO reader; stall timeout guards against a source that empties mid-record.

Parameters:
- NUM_SRC, 4, number of source FIFOs (2..8).
- RECORD_WORDS, 3, words per atomic record (1..15).
- TIMEOUT, 255, max consecutive mid-record stall cycles before abort (1..65535).

Ports:
- BUS_CLK  in  1  single clock; all logic rising-edge.
- BUS_RST_N  in  1  reset, synchronous, active-low.
- SRC_ENABLE  in  NUM_SRC  per-source arbitration enable mask.
- SRC_FIFO_EMPTY  in  NUM_SRC  per-source FIFO empty.
- SRC_FIFO_DATA  in  32*NUM_SRC  per-source FWFT data; source i at bits [32*i+31:32*i].
- SRC_FIFO_READ  out  NUM_SRC  per-source pop strobe.
- FIFO_READ  in  1  downstream pop strobe.
- FIFO_EMPTY  out  1  merged stream empty.
- FIFO_DATA  out  32  merged FWFT data.
- GRANT  out  NUM_SRC  one-hot current grant; 0 when idle.
- ERROR  out  1  sticky stall-timeout flag.
- ERROR_CLR  in  1  clears ERROR.

Behaviour:
- Reset (BUS_RST_N=0 at edge): state IDLE, GRANT=0, word_cnt=0, stall_cnt=0, ERROR=0, rr pointer so source 0 has highest priority next. Combinational outputs then give FIFO_EMPTY=1, SRC_FIFO_READ=0, FIFO_DATA=0. Reset mid-record abandons the record; the source FIFO keeps its unread words.
- Request: req[i] = SRC_ENABLE[i] & ~SRC_FIFO_EMPTY[i].
- IDLE: if any req, register one-hot GRANT of the first requesting source at or after the rr pointer (cyclic). Go to XFER next cycle. Arbitration latency is 1 cycle from req to FIFO_EMPTY=0.
- XFER, combinational:
  - FIFO_DATA = granted source data.
  - FIFO_EMPTY = SRC_FIFO_EMPTY[g].
  - SRC_FIFO_READ[g] = FIFO_READ & ~FIFO_EMPTY.
  - All other SRC_FIFO_READ = 0.
- Handshake: beat = FIFO_READ & ~FIFO_EMPTY.
  - Each beat increments word_cnt and clears stall_cnt.
  - A beat with word_cnt==RECORD_WORDS-1 clears word_cnt and GRANT, sets rr pointer to g+1 mod NUM_SRC, and returns to IDLE. One bubble cycle between records.
- FIFO_READ while FIFO_EMPTY=1 is ignored (no pop, no count).
- Stall: in XFER with SRC_FIFO_EMPTY[g]=1, stall_cnt increments. A downstream-held stall (source non-empty, FIFO_READ=0) never counts. When stall_cnt reaches TIMEOUT: set ERROR, release to IDLE, advance rr pointer, clear word_cnt. The partial record is delivered truncated.
- SRC_ENABLE[g] dropping during XFER does not abort; the record completes.
- ERROR: set has priority over ERROR_CLR in the same cycle.
- Counter widths: word_cnt 4 bits; stall_cnt 16 bits, saturating.
- FIFO_DATA when FIFO_EMPTY=1 is don't-care for verification, except after reset (0).

Decomposition:
- Shared package timestamp_pkg holds:
  - state encoding (IDLE, XFER);
  - DATA_WIDTH=32;
  - a function rr_pick(req, ptr) returning the one-hot cyclic-priority grant.
- One sub-module is natural: rr_priority_sel, a combinational cyclic-priority one-hot selector, reusable by other basil arbiters.
- Data/read muxing stays in the top.

Test Plan:
- Reset: BUS_RST_N=0 for 2 cycles with all sources full -> FIFO_EMPTY=1, GRANT=0, SRC_FIFO_READ=0, ERROR=0 throughout and 1 cycle after release.
- Single source: src1 holds records A0,A1,A2, FIFO_READ=1 continuously -> GRANT=4'b0010 one cycle after reset release. FIFO_DATA A0,A1,A2 on 3 consecutive beats, then a 1-cycle bubble, then FIFO_EMPTY=1.
- Fairness: all 4 sources hold 2 records each, reader always ready -> grant order 0,1,2,3,0,1,2,3. 24 words out, never interleaved within a record.
- Backpressure: src2 granted, FIFO_READ toggles 1,0,1,0,... -> 3 words delivered over 5 cycles, stall_cnt stays 0, ERROR=0.
- Timeout (TIMEOUT=4): src0 supplies 1 word then empties -> after 4 empty cycles ERROR=1 and GRANT moves to next requester. ERROR_CLR pulse -> ERROR=0 next cycle.
- Mid-record disable plus mid-record reset: drop SRC_ENABLE[g] after word 1 -> record still completes. Then assert BUS_RST_N=0 after word 1 of a new record -> GRANT=0 next cycle, and source 0 is granted first after release.
